// File: rtl/gate_sequencer.sv
// gate_sequencer: clear/gate/latch sequencing, overflow tracking and digit scan for the 8-digit BCD counter.
// Latency: all outputs registered except ctr_enable (combinational); no backpressure, inputs always accepted.
module gate_sequencer #(
    parameter int TICK_DIV   = 100000,
    parameter int SCAN_DIV   = 50000,
    parameter int HOLD_TICKS = 100
) (
    input  logic       clk_in,
    input  logic       nreset,
    input  logic       sig_edge,
    input  logic [1:0] range,
    input  logic       run,
    input  logic       single,
    input  logic       carry_in,
    output logic       ctr_enable,
    output logic       reset_ctr,
    output logic       latchit,
    output logic [2:0] digit_select,
    output logic       gate_active,
    output logic       busy,
    output logic       result_valid,
    output logic       overflow
);

    localparam int MAX_TICKS = (HOLD_TICKS > 10000) ? HOLD_TICKS : 10000;
    localparam int TW        = $clog2(MAX_TICKS + 1);
    localparam int PW        = $clog2(TICK_DIV);
    localparam int SW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_GATE,
        S_SETTLE,
        S_LATCH,
        S_RELEASE,
        S_HOLD
    } state_t;

    state_t        state_q, state_d;
    logic          step_q, step_d;
    logic [1:0]    range_q, range_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [TW-1:0] tick_q, tick_d;
    logic          sticky_q, sticky_d;
    logic          reset_ctr_q, reset_ctr_d;
    logic          latchit_q, latchit_d;
    logic          gate_active_q, gate_active_d;
    logic          busy_q, busy_d;
    logic          result_valid_q, result_valid_d;
    logic          overflow_q, overflow_d;
    logic [SW-1:0] scan_q, scan_d;
    logic [2:0]    digit_q, digit_d;

    logic [TW-1:0] gate_last;
    logic          pre_wrap;

    assign ctr_enable = sig_edge & gate_active_q;
    assign pre_wrap   = (pre_q == PRE_LAST);

    // Last tick index of the gate, from the range captured on entry to CLEAR.
    always_comb begin
        case (range_q)
            2'd0:    gate_last = TW'(9);
            2'd1:    gate_last = TW'(99);
            2'd2:    gate_last = TW'(999);
            default: gate_last = TW'(9999);
        endcase
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        range_d  = range_q;
        pre_d    = pre_q;
        tick_d   = tick_q;
        sticky_d = sticky_q;

        case (state_q)
            S_IDLE: begin
                if (run || single) begin
                    state_d  = S_CLEAR;
                    range_d  = range;
                    step_d   = 1'b0;
                    pre_d    = '0;
                    tick_d   = '0;
                    sticky_d = 1'b0;
                end
            end
            S_CLEAR: begin
                pre_d    = '0;
                tick_d   = '0;
                sticky_d = 1'b0;
                if (step_q) begin
                    state_d = S_GATE;
                    step_d  = 1'b0;
                end else begin
                    step_d = 1'b1;
                end
            end
            S_GATE: begin
                if (carry_in && ctr_enable) begin
                    sticky_d = 1'b1;
                end
                if (pre_wrap) begin
                    pre_d = '0;
                    if (tick_q == gate_last) begin
                        state_d = S_SETTLE;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end
            S_SETTLE: begin
                state_d = S_LATCH;
                step_d  = 1'b0;
            end
            S_LATCH: begin
                if (step_q) begin
                    state_d = S_RELEASE;
                    step_d  = 1'b0;
                end else begin
                    step_d = 1'b1;
                end
            end
            S_RELEASE: begin
                state_d = S_HOLD;
                pre_d   = '0;
                tick_d  = '0;
            end
            S_HOLD: begin
                if (pre_wrap) begin
                    pre_d = '0;
                    if (tick_q == HOLD_LAST) begin
                        tick_d = '0;
                        // run is only consulted here, so dropping it mid-cycle still publishes.
                        if (run) begin
                            state_d  = S_CLEAR;
                            range_d  = range;
                            step_d   = 1'b0;
                            sticky_d = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        reset_ctr_d    = (state_d == S_CLEAR);
        gate_active_d  = (state_d == S_GATE);
        latchit_d      = (state_d == S_LATCH);
        result_valid_d = (state_d == S_RELEASE);
        busy_d         = (state_d != S_IDLE);
        overflow_d     = (state_d == S_RELEASE) ? sticky_d : overflow_q;

        if (scan_q == SCAN_LAST) begin
            scan_d  = '0;
            digit_d = digit_q + 3'd1;
        end else begin
            scan_d  = scan_q + SW'(1);
            digit_d = digit_q;
        end
    end

    always_ff @(posedge clk_in or negedge nreset) begin
        if (!nreset) begin
            state_q        <= S_IDLE;
            step_q         <= 1'b0;
            range_q        <= '0;
            pre_q          <= '0;
            tick_q         <= '0;
            sticky_q       <= 1'b0;
            reset_ctr_q    <= 1'b0;
            latchit_q      <= 1'b0;
            gate_active_q  <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
            scan_q         <= '0;
            digit_q        <= '0;
        end else begin
            state_q        <= state_d;
            step_q         <= step_d;
            range_q        <= range_d;
            pre_q          <= pre_d;
            tick_q         <= tick_d;
            sticky_q       <= sticky_d;
            reset_ctr_q    <= reset_ctr_d;
            latchit_q      <= latchit_d;
            gate_active_q  <= gate_active_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
            overflow_q     <= overflow_d;
            scan_q         <= scan_d;
            digit_q        <= digit_d;
        end
    end

    assign reset_ctr    = reset_ctr_q;
    assign latchit      = latchit_q;
    assign gate_active  = gate_active_q;
    assign busy         = busy_q;
    assign result_valid = result_valid_q;
    assign overflow     = overflow_q;
    assign digit_select = digit_q;

endmodule

// File: tb/tb_gate_sequencer.sv
// Bench for gate_sequencer: random sig_edge/carry stimulus, measurement-level reference model, scoreboard monitor.
module tb_gate_sequencer;

    localparam int TICK_DIV   = 4;
    localparam int SCAN_DIV   = 2;
    localparam int HOLD_TICKS = 2;
    localparam int HOLD_CYC   = HOLD_TICKS * TICK_DIV;

    logic       clk_in = 1'b0;
    logic       nreset = 1'b1;
    logic       sig_edge = 1'b0;
    logic [1:0] range = 2'd0;
    logic       run = 1'b0;
    logic       single = 1'b0;
    logic       carry_in = 1'b0;
    logic       ctr_enable, reset_ctr, latchit, gate_active, busy, result_valid, overflow;
    logic [2:0] digit_select;

    gate_sequencer #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV), .HOLD_TICKS(HOLD_TICKS)) dut (
        .clk_in(clk_in), .nreset(nreset), .sig_edge(sig_edge), .range(range), .run(run),
        .single(single), .carry_in(carry_in), .ctr_enable(ctr_enable), .reset_ctr(reset_ctr),
        .latchit(latchit), .digit_select(digit_select), .gate_active(gate_active), .busy(busy),
        .result_valid(result_valid), .overflow(overflow)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int start;
        int glen;
        int en;
        bit ovf;
    } res_t;

    res_t rq[$];
    bit   hq[$];

    // Reference model: one measurement = CLEAR(2) + gate(L) + SETTLE(1) + LATCH(2) + RELEASE(1) + HOLD.
    bit sig_mode = 1'b0, carry_mode = 1'b0, run_lvl = 1'b0;
    logic [1:0] range_lvl = 2'd0;
    bit m_active = 1'b0;
    int m_start, m_L, m_en;
    bit m_ovf;

    function automatic int gate_len_of(input logic [1:0] r);
        int t;
        t = 10;
        for (int i = 0; i < int'(r); i++) t = t * 10;
        return t * TICK_DIV;
    endfunction

    task automatic start_meas(input int k);
        m_active = 1'b1;
        m_start  = k;
        m_L      = gate_len_of(range);
        m_en     = 0;
        m_ovf    = 1'b0;
    endtask

    task automatic model_update();
        int   rel;
        res_t r;
        if (m_active) begin
            rel = cyc - m_start;
            if (rel >= 2 && rel < 2 + m_L) begin
                if (sig_edge) m_en++;
                if (sig_edge && carry_in) m_ovf = 1'b1;
            end
            if (rel == 2 + m_L) begin
                r.start = m_start; r.glen = m_L; r.en = m_en; r.ovf = m_ovf;
                rq.push_back(r);
            end
            if (rel == 5 + m_L + HOLD_CYC) begin
                hq.push_back(run);
                if (run) start_meas(cyc + 1);
                else m_active = 1'b0;
            end
        end else if (run || single) begin
            start_meas(cyc + 1);
        end
    endtask

    task automatic step(input bit sgl);
        @(posedge clk_in);
        #1;
        single   = sgl;
        sig_edge = sig_mode ? 1'b1 : 1'($urandom_range(0, 1));
        carry_in = carry_mode ? 1'($urandom_range(0, 1)) : 1'b0;
        run      = run_lvl;
        range    = range_lvl;
        model_update();
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (m_active && guard < 60000) begin
            step(1'b0);
            guard++;
        end
        repeat (3) step(1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctr_enable"}, ctr_enable, 0);
        chk({tag, "_reset_ctr"}, reset_ctr, 0);
        chk({tag, "_latchit"}, latchit, 0);
        chk({tag, "_digit_select"}, digit_select, 0);
        chk({tag, "_gate_active"}, gate_active, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_result_valid"}, result_valid, 0);
        chk({tag, "_overflow"}, overflow, 0);
    endtask

    // Digit scan: after m clock edges out of reset the index is (m / SCAN_DIV) mod 8.
    int scan_m = 0;
    always @(posedge clk_in or negedge nreset) begin
        if (!nreset) scan_m <= 0;
        else scan_m <= scan_m + 1;
    end
    always @(negedge clk_in) begin
        if (nreset) chk("digit_select", digit_select, (scan_m / SCAN_DIV) % 8);
    end

    // Monitor: reconstructs each measurement from the outputs and pops expectations.
    int clear_start, clear_len, gate_start, gate_len, en_cnt, latch_start, latch_len, hold_len;
    bit in_hold = 1'b0, prev_rc = 1'b0, prev_ga = 1'b0, prev_la = 1'b0, ovf_prev = 1'b0;

    always @(negedge clk_in) begin
        res_t e;
        bit   exp_clear;
        if (!nreset) begin
            in_hold = 1'b0; prev_rc = 1'b0; prev_ga = 1'b0; prev_la = 1'b0; ovf_prev = 1'b0;
            clear_len = 0; gate_len = 0; en_cnt = 0; latch_len = 0;
        end else begin
            if (!gate_active) chk("ctr_enable_outside_gate", ctr_enable, 0);
            if (!result_valid) chk("overflow_stable", overflow, ovf_prev);
            ovf_prev = overflow;
            if (in_hold) begin
                if (busy && !reset_ctr) begin
                    hold_len++;
                end else begin
                    in_hold = 1'b0;
                    chk("hold_len", hold_len, HOLD_CYC);
                    if (hq.size() == 0) begin
                        chk("hold_end_expected", 0, 1);
                    end else begin
                        exp_clear = hq.pop_front();
                        chk("hold_exit_to_clear", reset_ctr, exp_clear);
                        chk("hold_exit_busy", busy, exp_clear);
                    end
                end
            end
            if (reset_ctr && !prev_rc) begin
                clear_start = cyc; clear_len = 0; gate_len = 0; en_cnt = 0; latch_len = 0;
                gate_start = -1; latch_start = -1;
            end
            if (reset_ctr) clear_len++;
            if (gate_active) begin
                if (!prev_ga) gate_start = cyc;
                gate_len++;
                if (ctr_enable) en_cnt++;
            end
            if (latchit) begin
                if (!prev_la) latch_start = cyc;
                latch_len++;
            end
            if (result_valid) begin
                if (rq.size() == 0) begin
                    chk("result_expected", 0, 1);
                end else begin
                    e = rq.pop_front();
                    chk("clear_start", clear_start, e.start);
                    chk("clear_len", clear_len, 2);
                    chk("gate_start", gate_start, e.start + 2);
                    chk("gate_len", gate_len, e.glen);
                    chk("enable_count", en_cnt, e.en);
                    chk("latch_start", latch_start, e.start + 3 + e.glen);
                    chk("latch_len", latch_len, 2);
                    chk("result_valid_cycle", cyc, e.start + 5 + e.glen);
                    chk("overflow_at_release", overflow, e.ovf);
                end
                in_hold  = 1'b1;
                hold_len = 0;
            end
            prev_rc = reset_ctr;
            prev_ga = gate_active;
            prev_la = latchit;
        end
    end

    initial begin
        int guard;
        #2 nreset = 1'b0;
        repeat (3) @(posedge clk_in);
        #1 chk_all_zero("reset");
        @(posedge clk_in);
        #1 nreset = 1'b1;
        repeat (5) step(1'b0);

        // Single shot, random edges, with a stray single during the gate that must be ignored.
        step(1'b1);
        repeat (20) step(1'b0);
        step(1'b1);
        wait_idle();

        // sig_edge held high for the whole gate.
        sig_mode = 1'b1;
        step(1'b1);
        wait_idle();
        sig_mode = 1'b0;

        // Overflow set by carry, then cleared by a carry-free measurement.
        carry_mode = 1'b1;
        sig_mode   = 1'b1;
        step(1'b1);
        wait_idle();
        carry_mode = 1'b0;
        sig_mode   = 1'b0;
        step(1'b1);
        wait_idle();

        // Continuous mode, range 1: two full repeats, then run dropped inside the third gate.
        range_lvl = 2'd1;
        run_lvl   = 1'b1;
        step(1'b0);
        repeat (2 * (14 + 400) + 200) step(1'b0);
        run_lvl = 1'b0;
        wait_idle();
        range_lvl = 2'd0;

        // Reset in the middle of a gate.
        step(1'b1);
        repeat (20) step(1'b0);
        @(posedge clk_in);
        #1 nreset = 1'b0;
        m_active = 1'b0;
        #1 chk_all_zero("abort");
        repeat (3) @(posedge clk_in);
        #1 nreset = 1'b1;
        repeat (30) begin
            step(1'b0);
            chk("idle_after_abort", {latchit, busy, result_valid}, 0);
        end
        step(1'b1);
        wait_idle();

        // Range changed mid-gate only affects the following measurement.
        run_lvl = 1'b1;
        step(1'b0);
        repeat (10) step(1'b0);
        range_lvl = 2'd3;
        guard = 0;
        while (!(m_active && m_L == gate_len_of(2'd3) && cyc - m_start == 100) && guard < 2000) begin
            step(1'b0);
            guard++;
        end
        chk("long_gate_reached", guard < 2000, 1);
        run_lvl = 1'b0;
        wait_idle();

        chk("results_drained", rq.size(), 0);
        chk("holds_drained", hq.size(), 0);
        chk("final_busy", busy, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
